peak_readout_ser: RTL and testbench

PEAK_READOUT_SER -- requirements
Module: peak_readout_ser

---
 rtl/peak_readout_ser.sv | 163 ++++++++++++++++
 tb/tb_peak_readout_ser.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peak_readout_ser.sv
// Serialises one peak bin per pixel from a histogram frame,
// with a one-frame pending buffer, window bounds and overrun flag.
//
// Ports:
//   clk, res       clock, async active-low reset
//   peakValid      one-cycle pulse, peakIn holds a final frame
//   peakIn         PIX peaks of NP bits, pixel p at [p*NP +: NP]
//   outReady       downstream accepts the current beat
//   ovrClr         synchronous clear of overrun
//   outValid       beat presented
//   outPixel       pixel index of the beat
//   outPeak        peak bin of the beat
//   outWinLo/Hi    peak -/+ GUARD, saturated to [0, 2^NP-1]
//   busy           frame active or pending
//   overrun        sticky, a frame was dropped
module peak_readout_ser #(
  parameter int NP    = 10,
  parameter int PIX   = 3,
  parameter int GUARD = 2
) (
  input  logic                clk,
  input  logic                res,
  input  logic                peakValid,
  input  logic [PIX*NP-1:0]   peakIn,
  input  logic                outReady,
  input  logic                ovrClr,
  output logic                outValid,
  output logic [((PIX>1)?$clog2(PIX):1)-1:0] outPixel,
  output logic [NP-1:0]       outPeak,
  output logic [NP-1:0]       outWinLo,
  output logic [NP-1:0]       outWinHi,
  output logic                busy,
  output logic                overrun
);

  localparam int PW = (PIX > 1) ? $clog2(PIX) : 1;
  localparam logic [PW-1:0] LAST = PW'(PIX - 1);
  localparam logic [NP:0] G    = (NP+1)'(GUARD);
  localparam logic [NP:0] MAXV = {1'b0, {NP{1'b1}}};

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       idx_q, idx_d;
  logic [PIX*NP-1:0]   act_q, act_d;
  logic [PIX*NP-1:0]   pend_q, pend_d;
  logic                pfull_q, pfull_d;
  logic                ovr_q, ovr_d;

  logic                xfer;
  logic                last;
  logic                ovr_set;

  // State register
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
      idx_q   <= '0;
      act_q   <= '0;
      pend_q  <= '0;
      pfull_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      pfull_q <= pfull_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    act_d   = act_q;
    pend_d  = pend_q;
    pfull_d = pfull_q;
    ovr_set = 1'b0;
    xfer    = (state_q == SEND) && outReady;
    last    = xfer && (idx_q == LAST);

    case (state_q)
      IDLE: begin
        if (peakValid) begin
          act_d   = peakIn;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (last) begin
          idx_d = '0;
          // Last beat leaves: promote pending,
          // or take a coinciding new frame.
          if (pfull_q) begin
            act_d = pend_q;
            if (peakValid) begin
              pend_d = peakIn;
            end else begin
              pfull_d = 1'b0;
            end
          end else if (peakValid) begin
            act_d = peakIn;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer) begin
            idx_d = idx_q + PW'(1);
          end
          if (peakValid) begin
            if (!pfull_q) begin
              pend_d  = peakIn;
              pfull_d = 1'b1;
            end else begin
              ovr_set = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A drop in the clear cycle keeps the flag set.
    ovr_d = ovr_set | (ovr_q & ~ovrClr);
  end

  // Outputs, from registered state only
  logic [NP-1:0] peak;
  logic [NP:0]   ext;
  logic [NP:0]   hi_w;
  logic [NP-1:0] lo;
  logic [NP-1:0] hi;
  logic          send;

  always_comb begin
    peak = '0;
    for (int p = 0; p < PIX; p++) begin
      if (idx_q == PW'(p)) begin
        peak = act_q[p*NP +: NP];
      end
    end
    send = (state_q == SEND);
    ext  = {1'b0, peak};
    hi_w = ext + G;
    lo   = (ext < G) ? '0 : (peak - G[NP-1:0]);
    hi   = (hi_w > MAXV) ? {NP{1'b1}} : hi_w[NP-1:0];

    outValid = send;
    outPixel = send ? idx_q : '0;
    outPeak  = send ? peak : '0;
    outWinLo = send ? lo : '0;
    outWinHi = send ? hi : '0;
    busy     = send | pfull_q;
    overrun  = ovr_q;
  end

endmodule

// File: tb/tb_peak_readout_ser.sv
// Scoreboard bench for peak_readout_ser.
// Expected beats are queued at frame pulse, popped on transfer.
module tb_peak_readout_ser;

  localparam int NP  = 10;
  localparam int PIX = 3;
  localparam int GRD = 2;

  logic          clk = 1'b0;
  logic          res;
  logic          peakValid;
  logic [29:0]   peakIn;
  logic          outReady;
  logic          ovrClr;
  logic          outValid;
  logic [1:0]    outPixel;
  logic [9:0]    outPeak;
  logic [9:0]    outWinLo;
  logic [9:0]    outWinHi;
  logic          busy;
  logic          overrun;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int pix;
    int pk;
    int lo;
    int hi;
  } beat_t;

  beat_t q[$];
  beat_t mb;

  peak_readout_ser #(
    .NP(NP), .PIX(PIX), .GUARD(GRD)
  ) dut (
    .clk(clk), .res(res),
    .peakValid(peakValid), .peakIn(peakIn),
    .outReady(outReady), .ovrClr(ovrClr),
    .outValid(outValid), .outPixel(outPixel),
    .outPeak(outPeak), .outWinLo(outWinLo),
    .outWinHi(outWinHi), .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic beat_t mk(int pix, int pk);
    beat_t b;
    b.pix = pix;
    b.pk  = pk;
    b.lo  = (pk - GRD < 0) ? 0 : pk - GRD;
    b.hi  = (pk + GRD > 1023) ? 1023 : pk + GRD;
    return b;
  endfunction

  task automatic push3(int p0, int p1, int p2);
    q.push_back(mk(0, p0));
    q.push_back(mk(1, p1));
    q.push_back(mk(2, p2));
  endtask

  // Starts at posedge+1, returns at next posedge+1.
  task automatic pulse(int p0, int p1, int p2, bit keep);
    peakIn    = {10'(p2), 10'(p1), 10'(p0)};
    peakValid = 1'b1;
    if (keep) push3(p0, p1, p2);
    @(posedge clk);
    #1 peakValid = 1'b0;
  endtask

  task automatic count_valid(output int n, input int bound);
    n = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (outValid) n++;
      else if (n > 0) break;
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (res && outValid && outReady) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected got pix=%0d peak=%0d required none",
                 outPixel, outPeak);
      end else begin
        mb = q.pop_front();
        if (outPixel !== 2'(mb.pix) || outPeak !== 10'(mb.pk) ||
            outWinLo !== 10'(mb.lo) || outWinHi !== 10'(mb.hi)) begin
          failures++;
          $display("FAIL beat got (%0d,%0d,%0d,%0d) required (%0d,%0d,%0d,%0d)",
                   outPixel, outPeak, outWinLo, outWinHi,
                   mb.pix, mb.pk, mb.lo, mb.hi);
        end
      end
    end
  end

  task automatic chk_q_empty(string name);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s queue left=%0d required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (outValid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got v=%b b=%b o=%b required 0 0 0",
               outValid, busy, overrun);
    end
    checks++;
    if (outPixel !== 2'd0 || outPeak !== 10'd0 ||
        outWinLo !== 10'd0 || outWinHi !== 10'd0) begin
      failures++;
      $display("FAIL reset_data got %0d %0d %0d %0d required 0 0 0 0",
               outPixel, outPeak, outWinLo, outWinHi);
    end
    @(negedge clk);
    res = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int n;
    outReady = 1'b1;
    pulse(108, 1, 1023, 1);
    checks++;
    if (outValid !== 1'b1 || outPixel !== 2'd0) begin
      failures++;
      $display("FAIL basic_latency got v=%b pix=%0d required 1 0",
               outValid, outPixel);
    end
    count_valid(n, 10);
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL basic_count got %0d required 3", n);
    end
    checks++;
    if (outValid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle got v=%b b=%b required 0 0",
               outValid, busy);
    end
    chk_q_empty("basic_drain");
    @(posedge clk);
    #1;
  endtask

  task automatic test_stall();
    int vc;
    bit bad;
    vc  = 0;
    bad = 0;
    outReady = 1'b1;
    pulse(108, 1, 1023, 1);
    for (int c = 0; c < 10; c++) begin
      outReady = !(c >= 1 && c <= 4);
      @(negedge clk);
      if (outValid) vc++;
      if (c >= 1 && c <= 4 &&
          (outPixel !== 2'd1 || outPeak !== 10'd1 ||
           outWinLo !== 10'd0 || outWinHi !== 10'd3))
        bad = 1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL stall_hold got unstable beat 1 required (1,1,0,3)");
    end
    checks++;
    if (vc != 7) begin
      failures++;
      $display("FAIL stall_count got %0d required 7", vc);
    end
    chk_q_empty("stall_drain");
  endtask

  task automatic test_overrun();
    int n;
    outReady = 1'b0;
    pulse(10, 20, 30, 1);
    pulse(40, 50, 60, 1);
    pulse(70, 80, 90, 0);
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b1 || outPixel !== 2'd0) begin
      failures++;
      $display("FAIL ovr_set got o=%b b=%b pix=%0d required 1 1 0",
               overrun, busy, outPixel);
    end
    // Clear together with another drop: set wins.
    ovrClr = 1'b1;
    pulse(5, 6, 7, 0);
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_set_wins got %b required 1", overrun);
    end
    @(posedge clk);
    #1 ovrClr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_clear got %b required 0", overrun);
    end
    outReady = 1'b1;
    count_valid(n, 20);
    checks++;
    if (n != 6) begin
      failures++;
      $display("FAIL ovr_b2b_count got %0d required 6", n);
    end
    chk_q_empty("ovr_drain");
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int n;
    outReady = 1'b1;
    pulse(100, 200, 300, 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    pulse(400, 1022, 0, 1);
    checks++;
    if (outValid !== 1'b1 || outPixel !== 2'd0 ||
        outPeak !== 10'd400 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL b2b_direct got v=%b pix=%0d pk=%0d o=%b required 1 0 400 0",
               outValid, outPixel, outPeak, overrun);
    end
    count_valid(n, 10);
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL b2b_count got %0d required 3", n);
    end
    chk_q_empty("b2b_drain");
    @(posedge clk);
    #1;
  endtask

  task automatic test_last_pending_full();
    int n;
    outReady = 1'b0;
    pulse(11, 12, 13, 1);
    pulse(21, 22, 23, 1);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    pulse(31, 32, 33, 1);
    checks++;
    if (outPeak !== 10'd21 || busy !== 1'b1 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL lastfull_promote got pk=%0d b=%b o=%b required 21 1 0",
               outPeak, busy, overrun);
    end
    count_valid(n, 20);
    checks++;
    if (n != 6) begin
      failures++;
      $display("FAIL lastfull_count got %0d required 6", n);
    end
    chk_q_empty("lastfull_drain");
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int vc;
    outReady = 1'b1;
    pulse(500, 600, 700, 1);
    @(posedge clk);
    #1 outReady = 1'b0;
    #2 res = 1'b0;
    #1;
    checks++;
    if (outValid !== 1'b0 || busy !== 1'b0 || outPeak !== 10'd0) begin
      failures++;
      $display("FAIL rstmid_async got v=%b b=%b pk=%0d required 0 0 0",
               outValid, busy, outPeak);
    end
    q.delete();
    @(negedge clk);
    res = 1'b1;
    outReady = 1'b1;
    vc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (outValid) vc++;
    end
    checks++;
    if (vc != 0) begin
      failures++;
      $display("FAIL rstmid_quiet got %0d valid cycles required 0", vc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_release_pulse();
    int n;
    res = 1'b0;
    @(negedge clk);
    res = 1'b1;
    outReady = 1'b1;
    peakIn = {10'd1021, 10'd2, 10'd0};
    peakValid = 1'b1;
    push3(0, 2, 1021);
    @(posedge clk);
    #1 peakValid = 1'b0;
    checks++;
    if (outValid !== 1'b1 || outPeak !== 10'd0 || outWinHi !== 10'd2) begin
      failures++;
      $display("FAIL release_accept got v=%b pk=%0d hi=%0d required 1 0 2",
               outValid, outPeak, outWinHi);
    end
    count_valid(n, 10);
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL release_count got %0d required 3", n);
    end
    chk_q_empty("release_drain");
  endtask

  initial begin
    res       = 1'b0;
    peakValid = 1'b0;
    peakIn    = '0;
    outReady  = 1'b0;
    ovrClr    = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_overrun();
    test_back_to_back();
    test_last_pending_full();
    test_reset_mid();
    test_release_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
